setup_move_sequencer: RTL and testbench

- Schedules the cube-turning moves between sticker observations during state determination.
- Accepts a one-cycle step request plus the 6-bit observation counter from the state-determination FSM.
- Replays that step's move list from an internal ROM to the motor driver over a valid/ready/done handshake.
- After the last move and a settle delay, pulses color_sensor_stable so the FSM may sample the sensors.

---
 rtl/setup_move_sequencer_if.sv | 24 ++
 rtl/setup_move_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_setup_move_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/setup_move_sequencer_if.sv
// Request / move handshake between the state-determination FSM, the move
// sequencer and the motor driver.
interface setup_move_sequencer_if;
    logic       send_setup_moves;
    logic [5:0] counter;
    logic       move_ready;
    logic       move_done;
    logic       move_valid;
    logic [2:0] move_face;
    logic [1:0] move_turn;
    logic       color_sensor_stable;
    logic       busy;
    logic       error;

    modport slave (
        input  send_setup_moves, counter, move_ready, move_done,
        output move_valid, move_face, move_turn, color_sensor_stable, busy, error
    );

    modport master (
        output send_setup_moves, counter, move_ready, move_done,
        input  move_valid, move_face, move_turn, color_sensor_stable, busy, error
    );
endinterface

// File: rtl/setup_move_sequencer.sv
// Replays the cube-turning move list for one observation step to the motor
// driver, waits for the cube to settle, then pulses color_sensor_stable.
module setup_move_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned LAST_STEP     = 48
) (
    input logic                   clock,
    input logic                   reset,
    setup_move_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, SETTLE, PULSE} state_t;

    localparam logic [2:0]  F_U = 3'd0, F_L = 3'd1, F_F = 3'd2, F_R = 3'd3, F_B = 3'd4;
    localparam logic [1:0]  T_CW = 2'd0, T_CCW = 2'd1, T_HALF = 2'd2;
    localparam logic [5:0]  LAST_K      = 6'(LAST_STEP);
    localparam logic [19:0] SETTLE_LOAD = 20'(SETTLE_CYCLES);

    function automatic logic [4:0] mv(input logic [2:0] f, input logic [1:0] t);
        return {f, t};
    endfunction

    // Setup and teardown lists of the same batch always have the same length.
    function automatic logic [3:0] batch_len(input logic [3:0] b);
        case (b)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 4'd2;
            4'd7, 4'd8, 4'd9, 4'd10:      return 4'd6;
            4'd11:                        return 4'd4;
            default:                      return 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] setup_move(input logic [3:0] b, input logic [2:0] i);
        logic [4:0] m;
        m = mv(F_U, T_CW);
        case ({b, i})
            {4'd1, 3'd0}:  m = mv(F_F, T_CW);   {4'd1, 3'd1}:  m = mv(F_B, T_CCW);
            {4'd2, 3'd0}:  m = mv(F_L, T_CCW);  {4'd2, 3'd1}:  m = mv(F_R, T_CW);
            {4'd3, 3'd0}:  m = mv(F_F, T_CCW);  {4'd3, 3'd1}:  m = mv(F_B, T_CW);
            {4'd4, 3'd0}:  m = mv(F_L, T_CW);   {4'd4, 3'd1}:  m = mv(F_R, T_CCW);
            {4'd5, 3'd0}:  m = mv(F_L, T_HALF); {4'd5, 3'd1}:  m = mv(F_R, T_HALF);
            {4'd7, 3'd0}:  m = mv(F_F, T_CW);   {4'd7, 3'd1}:  m = mv(F_B, T_CCW);
            {4'd7, 3'd2}:  m = mv(F_L, T_CW);   {4'd7, 3'd3}:  m = mv(F_U, T_CW);
            {4'd7, 3'd4}:  m = mv(F_F, T_CW);   {4'd7, 3'd5}:  m = mv(F_B, T_CCW);
            {4'd8, 3'd0}:  m = mv(F_L, T_CCW);  {4'd8, 3'd1}:  m = mv(F_R, T_CW);
            {4'd8, 3'd2}:  m = mv(F_F, T_CW);   {4'd8, 3'd3}:  m = mv(F_U, T_CCW);
            {4'd8, 3'd4}:  m = mv(F_L, T_CCW);  {4'd8, 3'd5}:  m = mv(F_R, T_CW);
            {4'd9, 3'd0}:  m = mv(F_F, T_CCW);  {4'd9, 3'd1}:  m = mv(F_B, T_CW);
            {4'd9, 3'd2}:  m = mv(F_R, T_CW);   {4'd9, 3'd3}:  m = mv(F_U, T_CW);
            {4'd9, 3'd4}:  m = mv(F_F, T_CCW);  {4'd9, 3'd5}:  m = mv(F_B, T_CW);
            {4'd10, 3'd0}: m = mv(F_L, T_CW);   {4'd10, 3'd1}: m = mv(F_R, T_CCW);
            {4'd10, 3'd2}: m = mv(F_B, T_CCW);  {4'd10, 3'd3}: m = mv(F_U, T_CW);
            {4'd10, 3'd4}: m = mv(F_L, T_CW);   {4'd10, 3'd5}: m = mv(F_R, T_CCW);
            {4'd11, 3'd0}: m = mv(F_R, T_HALF); {4'd11, 3'd1}: m = mv(F_L, T_HALF);
            {4'd11, 3'd2}: m = mv(F_F, T_HALF); {4'd11, 3'd3}: m = mv(F_B, T_HALF);
            default:       m = mv(F_U, T_CW);
        endcase
        return m;
    endfunction

    function automatic logic [4:0] teardown_move(input logic [3:0] b, input logic [2:0] i);
        logic [4:0] m;
        m = mv(F_U, T_CW);
        case ({b, i})
            {4'd1, 3'd0}:  m = mv(F_B, T_CW);   {4'd1, 3'd1}:  m = mv(F_F, T_CCW);
            {4'd2, 3'd0}:  m = mv(F_R, T_CCW);  {4'd2, 3'd1}:  m = mv(F_L, T_CW);
            {4'd3, 3'd0}:  m = mv(F_B, T_CCW);  {4'd3, 3'd1}:  m = mv(F_F, T_CW);
            {4'd4, 3'd0}:  m = mv(F_R, T_CW);   {4'd4, 3'd1}:  m = mv(F_L, T_CCW);
            {4'd5, 3'd0}:  m = mv(F_L, T_HALF); {4'd5, 3'd1}:  m = mv(F_R, T_HALF);
            {4'd7, 3'd0}:  m = mv(F_B, T_CW);   {4'd7, 3'd1}:  m = mv(F_F, T_CCW);
            {4'd7, 3'd2}:  m = mv(F_U, T_CCW);  {4'd7, 3'd3}:  m = mv(F_L, T_CCW);
            {4'd7, 3'd4}:  m = mv(F_B, T_CW);   {4'd7, 3'd5}:  m = mv(F_F, T_CCW);
            {4'd8, 3'd0}:  m = mv(F_R, T_CCW);  {4'd8, 3'd1}:  m = mv(F_L, T_CW);
            {4'd8, 3'd2}:  m = mv(F_U, T_CW);   {4'd8, 3'd3}:  m = mv(F_F, T_CCW);
            {4'd8, 3'd4}:  m = mv(F_R, T_CCW);  {4'd8, 3'd5}:  m = mv(F_L, T_CW);
            {4'd9, 3'd0}:  m = mv(F_B, T_CCW);  {4'd9, 3'd1}:  m = mv(F_F, T_CW);
            {4'd9, 3'd2}:  m = mv(F_U, T_CCW);  {4'd9, 3'd3}:  m = mv(F_R, T_CCW);
            {4'd9, 3'd4}:  m = mv(F_B, T_CCW);  {4'd9, 3'd5}:  m = mv(F_F, T_CW);
            {4'd10, 3'd0}: m = mv(F_R, T_CW);   {4'd10, 3'd1}: m = mv(F_L, T_CCW);
            {4'd10, 3'd2}: m = mv(F_U, T_CCW);  {4'd10, 3'd3}: m = mv(F_B, T_CW);
            {4'd10, 3'd4}: m = mv(F_R, T_CW);   {4'd10, 3'd5}: m = mv(F_L, T_CCW);
            {4'd11, 3'd0}: m = mv(F_B, T_HALF); {4'd11, 3'd1}: m = mv(F_F, T_HALF);
            {4'd11, 3'd2}: m = mv(F_L, T_HALF); {4'd11, 3'd3}: m = mv(F_R, T_HALF);
            default:       m = mv(F_U, T_CW);
        endcase
        return m;
    endfunction

    // Step k: [U if k>0], then on batch boundaries teardown(b-1) and setup(b).
    function automatic logic [3:0] step_len(input logic [5:0] k);
        logic [3:0] b;
        logic [3:0] su;
        b  = k[5:2];
        su = (b <= 4'd11) ? batch_len(b) : 4'd0;
        if (k == 6'd0)         return 4'd0;
        if (k[1:0] != 2'd0)    return 4'd1;
        return 4'd1 + batch_len(b - 4'd1) + su;
    endfunction

    function automatic logic [4:0] step_move(input logic [5:0] k, input logic [3:0] idx);
        logic [3:0] b;
        logic [3:0] td_b;
        logic [3:0] j;
        logic [3:0] tl;
        logic [3:0] sj;
        b    = k[5:2];
        td_b = b - 4'd1;
        j    = idx - 4'd1;
        tl   = batch_len(td_b);
        sj   = j - tl;
        if (idx == 4'd0) return mv(F_U, T_CW);
        if (j < tl)      return teardown_move(td_b, j[2:0]);
        return setup_move(b, sj[2:0]);
    endfunction

    state_t      state_q;
    logic [5:0]  step_q;
    logic [3:0]  idx_q;
    logic [3:0]  len_q;
    logic [19:0] settle_q;
    logic        move_valid_q;
    logic [2:0]  move_face_q;
    logic [1:0]  move_turn_q;
    logic        stable_q;
    logic        busy_q;
    logic        error_q;

    logic [3:0]  rd_idx_d;
    logic [4:0]  next_move_d;
    logic [3:0]  step_len_d;

    always_comb begin
        rd_idx_d    = (state_q == FETCH) ? 4'd0 : idx_q + 4'd1;
        next_move_d = step_move(step_q, rd_idx_d);
        step_len_d  = step_len(step_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= 6'd0;
            idx_q        <= 4'd0;
            len_q        <= 4'd0;
            settle_q     <= 20'd0;
            move_valid_q <= 1'b0;
            move_face_q  <= 3'd0;
            move_turn_q  <= 2'd0;
            stable_q     <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (bus.send_setup_moves && (state_q != IDLE || bus.counter > LAST_K))
                error_q <= 1'b1;
            if (bus.move_done && state_q != WAIT_DONE)
                error_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.send_setup_moves && bus.counter <= LAST_K) begin
                        step_q  <= bus.counter;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    len_q <= step_len_d;
                    idx_q <= 4'd0;
                    if (step_len_d == 4'd0) begin
                        settle_q <= SETTLE_LOAD;
                        state_q  <= SETTLE;
                    end else begin
                        move_valid_q <= 1'b1;
                        {move_face_q, move_turn_q} <= next_move_d;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.move_ready) begin
                        move_valid_q <= 1'b0;
                        state_q      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.move_done) begin
                        if (idx_q == len_q - 4'd1) begin
                            settle_q <= SETTLE_LOAD;
                            state_q  <= SETTLE;
                        end else begin
                            idx_q        <= idx_q + 4'd1;
                            move_valid_q <= 1'b1;
                            {move_face_q, move_turn_q} <= next_move_d;
                            state_q      <= ISSUE;
                        end
                    end
                end
                // One cycle to load the timer, then SETTLE_CYCLES of countdown.
                SETTLE: begin
                    if (settle_q == 20'd0) begin
                        stable_q <= 1'b1;
                        state_q  <= PULSE;
                    end else begin
                        settle_q <= settle_q - 20'd1;
                    end
                end
                PULSE: begin
                    stable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.move_valid          = move_valid_q;
    assign bus.move_face           = move_face_q;
    assign bus.move_turn           = move_turn_q;
    assign bus.color_sensor_stable = stable_q;
    assign bus.busy                = busy_q;
    assign bus.error               = error_q;
endmodule

// File: tb/tb_setup_move_sequencer.sv
// Directed bench for setup_move_sequencer: replays several steps through a
// simple motor-driver model and checks moves, latencies and error handling.
module tb_setup_move_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    setup_move_sequencer_if bus();

    setup_move_sequencer #(
        .SETTLE_CYCLES(4),
        .LAST_STEP    (48)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_mv[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Request step k, serve every move (ready on request, done 3 cycles after
    // transfer), then wait for the stable pulse.
    task automatic do_step(input logic [5:0] k, input int stall_idx, input int stall_cyc,
                           input int inj_idx);
        int n;
        int budget;
        int lat;
        logic extra;
        logic gap;
        logic [4:0] m;
        n = exp_mv.size();
        bus.counter = k;
        bus.send_setup_moves = 1'b1;
        tick();
        bus.send_setup_moves = 1'b0;
        chk($sformatf("k%0d_busy_after_req", k), 32'(bus.busy), 1);
        chk($sformatf("k%0d_valid_at_fetch", k), 32'(bus.move_valid), 0);
        for (int i = 0; i < n; i++) begin
            budget = 0;
            while (!bus.move_valid && budget < 50) begin
                tick();
                budget++;
            end
            if (i == 0) chk($sformatf("k%0d_first_valid_lat", k), 32'(budget), 1);
            chk($sformatf("k%0d_valid%0d", k, i), 32'(bus.move_valid), 1);
            m = {bus.move_face, bus.move_turn};
            $display("step %0d move %0d face=%0d turn=%0d", k, i, bus.move_face, bus.move_turn);
            chk($sformatf("k%0d_move%0d", k, i), 32'(m), 32'(exp_mv[i]));
            if (i == inj_idx) begin
                bus.counter = 6'd7;
                bus.send_setup_moves = 1'b1;
                tick();
                bus.send_setup_moves = 1'b0;
                chk("err_on_busy_req", 32'(bus.error), 1);
                chk("valid_after_busy_req", 32'(bus.move_valid), 1);
            end
            if (i == stall_idx) begin
                repeat (stall_cyc) tick();
                chk("hold_valid", 32'(bus.move_valid), 1);
                chk("hold_move", 32'({bus.move_face, bus.move_turn}), 32'(m));
            end
            bus.move_ready = 1'b1;
            tick();
            bus.move_ready = 1'b0;
            chk($sformatf("k%0d_valid_drop%0d", k, i), 32'(bus.move_valid), 0);
            tick();
            tick();
            chk($sformatf("k%0d_no_reissue%0d", k, i), 32'(bus.move_valid), 0);
            bus.move_done = 1'b1;
            tick();
            bus.move_done = 1'b0;
        end
        lat = 1;
        extra = 1'b0;
        gap = 1'b0;
        while (!bus.color_sensor_stable && lat < 2000) begin
            if (bus.move_valid) extra = 1'b1;
            if (!bus.busy) gap = 1'b1;
            tick();
            lat++;
        end
        chk($sformatf("k%0d_stable_lat", k), 32'(lat), (n == 0) ? 7 : 6);
        chk($sformatf("k%0d_no_extra_move", k), 32'(extra), 0);
        chk($sformatf("k%0d_busy_held", k), 32'(gap), 0);
        chk($sformatf("k%0d_busy_at_pulse", k), 32'(bus.busy), 1);
        tick();
        chk($sformatf("k%0d_stable_one_cycle", k), 32'(bus.color_sensor_stable), 0);
        chk($sformatf("k%0d_busy_drop", k), 32'(bus.busy), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        logic seen;
        bus.send_setup_moves = 1'b0;
        bus.counter          = 6'd0;
        bus.move_ready       = 1'b0;
        bus.move_done        = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_valid",  32'(bus.move_valid), 0);
        chk("rst_face",   32'(bus.move_face), 0);
        chk("rst_turn",   32'(bus.move_turn), 0);
        chk("rst_stable", 32'(bus.color_sensor_stable), 0);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_error",  32'(bus.error), 0);

        exp_mv = {};
        do_step(6'd0, -1, 0, -1);

        exp_mv = '{5'd0};
        do_step(6'd5, -1, 0, -1);

        // U, B, F', L', R
        exp_mv = '{5'd0, 5'd16, 5'd9, 5'd5, 5'd12};
        do_step(6'd8, 1, 10, -1);

        // U + teardown(7) + setup(8)
        exp_mv = '{5'd0, 5'd16, 5'd9, 5'd1, 5'd5, 5'd16, 5'd9,
                   5'd5, 5'd12, 5'd8, 5'd1, 5'd5, 5'd12};
        do_step(6'd32, -1, 0, -1);

        // U, B2, F2, L2, R2
        exp_mv = '{5'd0, 5'd18, 5'd10, 5'd6, 5'd14};
        do_step(6'd48, -1, 0, -1);
        chk("no_error_after_normal_steps", 32'(bus.error), 0);

        // U, F, B' with a stray request while busy
        exp_mv = '{5'd0, 5'd8, 5'd17};
        do_step(6'd4, -1, 0, 1);
        chk("error_sticky", 32'(bus.error), 1);
        pulse_reset();
        chk("error_cleared_1", 32'(bus.error), 0);

        bus.counter = 6'd63;
        bus.send_setup_moves = 1'b1;
        tick();
        bus.send_setup_moves = 1'b0;
        chk("k63_error", 32'(bus.error), 1);
        chk("k63_not_busy", 32'(bus.busy), 0);
        seen = 1'b0;
        repeat (15) begin
            if (bus.color_sensor_stable || bus.move_valid) seen = 1'b1;
            tick();
        end
        chk("k63_no_activity", 32'(seen), 0);
        pulse_reset();
        chk("error_cleared_2", 32'(bus.error), 0);

        bus.move_done = 1'b1;
        tick();
        bus.move_done = 1'b0;
        chk("stray_done_error", 32'(bus.error), 1);
        pulse_reset();
        chk("error_cleared_3", 32'(bus.error), 0);

        // Reset while waiting for the first move of step 28 to finish
        bus.counter = 6'd28;
        bus.send_setup_moves = 1'b1;
        tick();
        bus.send_setup_moves = 1'b0;
        budget = 0;
        while (!bus.move_valid && budget < 50) begin
            tick();
            budget++;
        end
        chk("k28_valid", 32'(bus.move_valid), 1);
        chk("k28_move0", 32'({bus.move_face, bus.move_turn}), 0);
        $display("step 28 move 0 face=%0d turn=%0d", bus.move_face, bus.move_turn);
        bus.move_ready = 1'b1;
        tick();
        bus.move_ready = 1'b0;
        chk("k28_wait_done_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk("midrst_valid",  32'(bus.move_valid), 0);
        chk("midrst_busy",   32'(bus.busy), 0);
        chk("midrst_stable", 32'(bus.color_sensor_stable), 0);
        rst = 1'b0;
        tick();

        exp_mv = '{5'd0};
        do_step(6'd1, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
